// File: rtl/spi_wb_slave_if.sv
// spi_wb_slave_if: Wishbone classic single-cycle bus between master and the SPI register block.
interface spi_wb_slave_if;
    logic        cyc_in;
    logic        stb_in;
    logic        we_in;
    logic [4:0]  addr_in;
    logic [31:0] data_in;
    logic [3:0]  sel_in;
    logic [31:0] data_out;
    logic        ack_out;
    modport master (
        output cyc_in, stb_in, we_in, addr_in, data_in, sel_in,
        input  data_out, ack_out
    );
    modport slave (
        input  cyc_in, stb_in, we_in, addr_in, data_in, sel_in,
        output data_out, ack_out
    );
endinterface

// File: rtl/spi_wb_slave.sv
// spi_wb_slave: Wishbone register block holding SPI config/tx data, launching the shifter and capturing rx.
module spi_wb_slave #(
    parameter int          SS_NB     = 8,
    parameter logic [15:0] DIV_RESET = 16'h0000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    spi_wb_slave_if.slave     wb,
    output logic              int_out,
    input  logic              done_in,
    input  logic [31:0]       rx_data_in,
    output logic              go_out,
    output logic [31:0]       tx_data_out,
    output logic [5:0]        char_len_out,
    output logic              rx_neg_out,
    output logic              tx_neg_out,
    output logic              lsb_out,
    output logic [15:0]       divider_out,
    output logic [SS_NB-1:0]  ss_out
);
    localparam logic [13:0] CTRL_MASK = 14'h3E3F;
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        for (int b = 0; b < 4; b++) merge[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    endfunction
    logic              ack_q, ack_d, go_q, go_d, int_q, int_d;
    logic [31:0]       tx_q, tx_d, rx_q, rx_d, dat_q, dat_d;
    logic [13:0]       ctrl_q, ctrl_d;
    logic [15:0]       div_q, div_d;
    logic [SS_NB-1:0]  ss_q, ss_d;
    logic              acc, wr, rd;
    logic [2:0]        idx;
    logic [31:0]       ctrl_rd, ctrl_wr, div_wr, ss_wr, rd_mux;
    logic              unused_bits;
    assign acc = wb.cyc_in & wb.stb_in & ~ack_q;
    assign wr  = acc & wb.we_in;
    assign rd  = acc & ~wb.we_in;
    assign idx = wb.addr_in[4:2];
    // CTRL bit 8 is not stored: it always reflects the live go flag
    assign ctrl_rd = {18'b0, ctrl_q[13:9], go_q, ctrl_q[7:0]};
    assign ctrl_wr = merge(ctrl_rd, wb.data_in, wb.sel_in);
    assign div_wr  = merge({16'b0, div_q}, wb.data_in, wb.sel_in);
    assign ss_wr   = merge({{(32-SS_NB){1'b0}}, ss_q}, wb.data_in, wb.sel_in);
    assign unused_bits = ^{wb.addr_in[1:0], ctrl_q[8], ctrl_wr[31:14], div_wr[31:16], ss_wr[31:SS_NB]};
    always_comb begin
        tx_d   = (wr && idx == 3'd1 && !go_q) ? merge(tx_q, wb.data_in, wb.sel_in) : tx_q;
        ctrl_d = (wr && idx == 3'd2 && !go_q) ? ctrl_wr[13:0] & CTRL_MASK : ctrl_q;
        div_d  = (wr && idx == 3'd3 && !go_q) ? div_wr[15:0] : div_q;
        ss_d   = (wr && idx == 3'd4) ? ss_wr[SS_NB-1:0] : ss_q;
        go_d   = go_q ? ~done_in : (wr && idx == 3'd2 && ctrl_wr[8]);
        rx_d   = done_in ? rx_data_in : rx_q;
        int_d  = (done_in & ctrl_q[12]) | (int_q & ~acc);
        ack_d  = acc;
        rd_mux = idx == 3'd0 ? rx_q :
                 idx == 3'd1 ? tx_q :
                 idx == 3'd2 ? ctrl_rd :
                 idx == 3'd3 ? {16'b0, div_q} :
                 idx == 3'd4 ? {{(32-SS_NB){1'b0}}, ss_q} : 32'b0;
        dat_d  = rd ? rd_mux : 32'b0;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            int_q  <= 1'b0;
            go_q   <= 1'b0;
            tx_q   <= '0;
            rx_q   <= '0;
            ctrl_q <= '0;
            div_q  <= DIV_RESET;
            ss_q   <= '0;
        end else begin
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            int_q  <= int_d;
            go_q   <= go_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            ctrl_q <= ctrl_d;
            div_q  <= div_d;
            ss_q   <= ss_d;
        end
    end
    assign wb.ack_out   = ack_q;
    assign wb.data_out  = dat_q;
    assign int_out      = int_q;
    assign go_out       = go_q;
    assign tx_data_out  = tx_q;
    assign char_len_out = ctrl_q[5:0];
    assign rx_neg_out   = ctrl_q[9];
    assign tx_neg_out   = ctrl_q[10];
    assign lsb_out      = ctrl_q[11];
    assign divider_out  = div_q;
    assign ss_out       = ctrl_q[13] ? ss_q & {SS_NB{go_q}} : ss_q;
endmodule

// File: doc/spi_wb_slave.md
# spi_wb_slave

Wishbone classic slave register block for the SPI controller. It receives single read and write cycles from the Wishbone master, holds the SPI configuration and transmit data, and starts the SPI shift engine. It latches the engine's received word and raises a completion interrupt. It sits directly downstream of the Wishbone master and directly upstream of the SPI shifter.

## Interface
Parameters:
- SS_NB, 8: number of slave-select lines (1..8)
- DIV_RESET, 16'h0000: reset value of the clock divider register

Ports:
- clk_in  input  1  system clock; all state changes on its rising edge
- rst_in  input  1  synchronous, active-high reset
- cyc_in  input  1  Wishbone cycle
- stb_in  input  1  Wishbone strobe
- we_in  input  1  Wishbone write enable
- addr_in  input  5  byte address; word index = addr_in[4:2], addr_in[1:0] ignored
- data_in  input  32  Wishbone write data
- sel_in  input  4  byte selects; sel_in[n] covers data bits [8n+7:8n]
- data_out  output  32  Wishbone read data, registered
- ack_out  output  1  Wishbone acknowledge, registered
- int_out  output  1  transfer-complete interrupt
- done_in  input  1  one-cycle pulse from the shifter marking the end of a transfer
- rx_data_in  input  32  shifter receive word, valid when done_in=1
- go_out  output  1  starts the shifter; held high until done_in
- tx_data_out  output  32  transmit word
- char_len_out  output  6  bits per transfer; 0 encodes 32
- rx_neg_out, tx_neg_out, lsb_out  output  1 each  sample edge, drive edge, LSB-first
- divider_out  output  16  SCLK divider
- ss_out  output  SS_NB  slave-select enables, active-high

## Operation
- Register map by word index:
  - 0, RXDATA: read-only.
  - 1, TXDATA: read/write.
  - 2, CTRL: [5:0] CHAR_LEN, [8] GO, [9] RX_NEG, [10] TX_NEG, [11] LSB, [12] IE, [13] ASS; other bits read 0.
  - 3, DIVIDER: [15:0].
  - 4, SS: [SS_NB-1:0].
  - 5..7: read 0; writes are ignored but still acknowledged.
- Access: a cycle is accepted when cyc_in & stb_in & ~ack_out.
  - On the accepting edge, ack_out is set for exactly one cycle.
  - A write updates only the bytes whose sel_in bit is 1, on that same edge.
  - A read loads data_out with the full 32-bit register, ignoring sel_in.
  - data_out is 0 whenever ack_out=0.
- Busy rule: while go_out=1, writes to TXDATA, CTRL and DIVIDER are discarded but still acknowledged. SS remains writable.
- GO:
  - Writing CTRL with bit 8=1 while go_out=0 sets go_out on the write edge.
  - done_in clears go_out.
  - CTRL[8] reads back go_out.
- RX capture: on done_in, RXDATA <= rx_data_in. Bits above the character length are passed through unchanged; the shifter is responsible for them.
- Interrupt:
  - On done_in with IE=1, int_out is set.
  - Any accepted Wishbone access clears int_out.
  - If a set and a clear occur in the same cycle, the set wins.
- Slave select: ss_out = SS when ASS=0; ss_out = SS & {SS_NB{go_out}} when ASS=1.
- Reset values:
  - ack_out, data_out, int_out, go_out: 0.
  - TXDATA, RXDATA, CTRL, SS: 0.
  - DIVIDER: DIV_RESET.
  - ss_out: 0.

## Timing
- Wishbone latency:
  - Request sampled at edge N; ack_out and read data are valid after edge N and are cleared at edge N+1.
  - If stb_in is held high through the ack cycle, a second access is accepted at edge N+2, giving at most one ack every two cycles.
  - Register outputs (tx_data_out, char_len_out, divider_out, etc.) reflect a write one cycle after the write edge, i.e. coincident with ack_out.
- go_out rises on the write edge and falls on the edge that samples done_in=1. It is never cleared by a write of GO=0.
- done_in and a GO=1 write in the same cycle while busy: the write is discarded and go_out clears.
- cyc_in or stb_in dropped before ack_out: no state change and no ack.
- Reset mid-transfer: on the edge that samples rst_in=1, all outputs return to their reset values, including an in-flight ack_out.
- Reset has priority over every other event.

## Test plan
- Reset, then read all 8 word addresses:
  - Every read returns 0 except DIVIDER, which returns DIV_RESET.
  - Each ack_out lasts one cycle.
- Write TXDATA=32'hA5A5_1234 with sel_in=4'b0101, then read it back:
  - Readback is 32'h00A5_0034.
  - tx_data_out shows the same value.
- Write CTRL=32'h0000_1108 (CHAR_LEN=8, GO, IE):
  - go_out=1 and char_len_out=6'd8.
  - A write of 32'hFFFF_FFFF to TXDATA while busy leaves TXDATA unchanged.
- With go_out=1, pulse done_in with rx_data_in=32'h0000_00C3:
  - go_out=0 and int_out=1.
  - A read of RXDATA returns 32'h0000_00C3, and int_out clears on that access.
- Set SS=8'h04 and ASS=1:
  - ss_out=0 while idle.
  - ss_out=8'h04 only while go_out=1.
- Hold cyc_in=stb_in=1 for 6 cycles reading DIVIDER:
  - ack_out pattern is 0,1,0,1,0,1.
- Assert rst_in during a write's ack cycle:
  - ack_out=0 and the registers are reset on the next edge.
